alu_issue_stage: RTL

Sequential front-end for the combinational `alu`. It accepts ALU commands (operands plus select) over a valid/ready handshake and buffers them in a small FIFO. It presents one command at a time on the `alu` input ports, captures `alu_out` after a settle cycle, and returns the result downstream over a second valid/ready handshake. It sits directly upstream of `alu`, which it drives, and also consumes `alu`'s output.

---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_cmd_fifo.sv | 67 ++++++
 rtl/alu_issue_stage.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared widths and issue-stage FSM encoding for the alu and its front-end.
package alu_pkg;

  localparam int OP_W  = 4;
  localparam int SEL_W = 3;
  localparam int RES_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } issue_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command buffer in front of the ALU: DEPTH entries, registered occupancy,
// head entry visible combinationally on pop_data.
module alu_cmd_fifo #(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 11,
  parameter int FILL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  pop_data,
  output logic [FILL_W-1:0] fill,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]  mem_r [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [FILL_W-1:0] fill_r;
  logic              push_ok_s;
  logic              pop_ok_s;

  assign full      = (fill_r == FILL_W'(DEPTH));
  assign empty     = (fill_r == {FILL_W{1'b0}});
  assign push_ok_s = push && !full;
  assign pop_ok_s  = pop && !empty;
  assign pop_data  = mem_r[rd_ptr_r];
  assign fill      = fill_r;

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
    end
  end

  // Occupancy; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_r <= {FILL_W{1'b0}};
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   fill_r <= fill_r + FILL_W'(1);
        2'b01:   fill_r <= fill_r - FILL_W'(1);
        default: fill_r <= fill_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Sequential front-end for the combinational alu: buffers commands, drives the
// alu operands for a settle cycle, and returns the captured result.
module alu_issue_stage #(
  parameter int DEPTH = 4,
  parameter int OP_W  = alu_pkg::OP_W,
  parameter int SEL_W = alu_pkg::SEL_W,
  parameter int RES_W = alu_pkg::RES_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [OP_W-1:0]          cmd_a,
  input  logic [OP_W-1:0]          cmd_b,
  input  logic [SEL_W-1:0]         cmd_sel,
  output logic [OP_W-1:0]          alu_a,
  output logic [OP_W-1:0]          alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [RES_W-1:0]         alu_res,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [RES_W-1:0]         res_data,
  output logic [SEL_W-1:0]         res_sel,
  output logic [$clog2(DEPTH):0]   fill,
  output logic [7:0]               op_count
);

  import alu_pkg::*;

  localparam int CMD_W  = 2 * OP_W + SEL_W;
  localparam int FILL_W = $clog2(DEPTH) + 1;

  issue_state_t      state_r;
  issue_state_t      state_nxt_s;
  logic              pop_s;
  logic              hs_s;
  logic              full_s;
  logic              empty_s;
  logic [CMD_W-1:0]  head_s;
  logic [FILL_W-1:0] fill_s;

  logic [OP_W-1:0]   alu_a_r;
  logic [OP_W-1:0]   alu_b_r;
  logic [SEL_W-1:0]  alu_sel_r;
  logic              res_valid_r;
  logic [RES_W-1:0]  res_data_r;
  logic [SEL_W-1:0]  res_sel_r;
  logic [7:0]        op_count_r;

  alu_cmd_fifo #(
    .DEPTH  (DEPTH),
    .WIDTH  (CMD_W),
    .FILL_W (FILL_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (cmd_valid),
    .push_data ({cmd_sel, cmd_b, cmd_a}),
    .pop       (pop_s),
    .pop_data  (head_s),
    .fill      (fill_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign cmd_ready = !full_s;
  assign hs_s      = (state_r == HOLD) && res_ready;

  // Next-state and pop decision; a pop happens only from IDLE or on a HOLD handshake.
  always_comb begin
    pop_s       = 1'b0;
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!empty_s) begin
          pop_s       = 1'b1;
          state_nxt_s = EXEC;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EXEC: begin
        state_nxt_s = HOLD;
      end
      HOLD: begin
        if (res_ready) begin
          if (!empty_s) begin
            pop_s       = 1'b1;
            state_nxt_s = EXEC;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = HOLD;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, operand, result and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      alu_a_r     <= {OP_W{1'b0}};
      alu_b_r     <= {OP_W{1'b0}};
      alu_sel_r   <= {SEL_W{1'b0}};
      res_valid_r <= 1'b0;
      res_data_r  <= {RES_W{1'b0}};
      res_sel_r   <= {SEL_W{1'b0}};
      op_count_r  <= 8'd0;
    end else begin
      state_r <= state_nxt_s;
      // Operands move only on a pop so the alu inputs stay quiet in EXEC/HOLD.
      if (pop_s) begin
        {alu_sel_r, alu_b_r, alu_a_r} <= head_s;
      end
      if (state_r == EXEC) begin
        res_data_r  <= alu_res;
        res_sel_r   <= alu_sel_r;
        res_valid_r <= 1'b1;
      end else if (hs_s) begin
        res_valid_r <= 1'b0;
      end
      if (hs_s) begin
        op_count_r <= op_count_r + 8'd1;
      end
    end
  end

  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_sel   = alu_sel_r;
  assign res_valid = res_valid_r;
  assign res_data  = res_data_r;
  assign res_sel   = res_sel_r;
  assign fill      = fill_s;
  assign op_count  = op_count_r;

endmodule
